// File: rtl/adc_fp_if.sv
// Stream bundle for adc_fp: raw ADC samples in, calibrated fixed-point results out.
// master = sample source / result sink, slave = the converter.
interface adc_fp_if #(
    parameter int FP_WIDTH  = 64,
    parameter int ADC_WIDTH = 14
);
    logic signed [ADC_WIDTH-1:0] adc_code;
    logic                        adc_valid;
    logic                        adc_ready;
    logic [FP_WIDTH-1:0]         fp_out;
    logic                        fp_valid;
    logic                        fp_ready;
    logic                        sat_flag;

    modport master (
        output adc_code, adc_valid, fp_ready,
        input  adc_ready, fp_out, fp_valid, sat_flag
    );

    modport slave (
        input  adc_code, adc_valid, fp_ready,
        output adc_ready, fp_out, fp_valid, sat_flag
    );
endinterface

// File: rtl/adc_fp.sv
// ADC receive path: optional box-car average, code-to-volts scaling, calibration
// gain and offset with saturation; four-stage pipeline that stalls as a whole.
module adc_fp #(
    parameter int FP_WIDTH  = 64,
    parameter int INT_WIDTH = 16,
    parameter int ADC_WIDTH = 14,
    parameter int AVG_LOG2  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic [FP_WIDTH-1:0] ADC_CAL_GAIN,
    input  logic [FP_WIDTH-1:0] ADC_CAL_OFFSET,
    adc_fp_if.slave             io
);
    localparam int AW   = ADC_WIDTH + AVG_LOG2;
    localparam int CW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FRAC = FP_WIDTH - INT_WIDTH;
    localparam int PW   = 2 * FP_WIDTH;
    // -20 V / 16384 codes, i.e. -5 * 2^(FRAC-12)
    localparam logic signed [FP_WIDTH-1:0] K_SCALE = -(FP_WIDTH'(5) << (FRAC - 12));
    localparam logic [FP_WIDTH-1:0] SAT_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam logic [FP_WIDTH-1:0] SAT_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};

    logic                        en, accept, win_first, win_last;
    logic signed [AW-1:0]        acc_q, acc_d, acc_sum, code_ext, avg_full;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        s1_valid_q, s1_valid_d;
    logic signed [ADC_WIDTH-1:0] s1_avg_q, s1_avg_d;
    logic                        s2_valid_q, s2_valid_d;
    logic signed [FP_WIDTH-1:0]  s2_volts_q, s2_volts_d;
    logic                        s3_valid_q, s3_valid_d;
    logic                        s3_sat_q, s3_sat_d;
    logic [FP_WIDTH-1:0]         s3_prod_q, s3_prod_d;
    logic                        fp_valid_q, fp_valid_d;
    logic                        sat_flag_q, sat_flag_d;
    logic [FP_WIDTH-1:0]         fp_out_q, fp_out_d;

    logic signed [FP_WIDTH-1:0]  avg_fp;
    logic signed [PW-1:0]        s2_full, s3_full;
    logic [INT_WIDTH:0]          s3_hi;
    logic [FP_WIDTH:0]           sum;
    logic [FP_WIDTH-1:0]         volts_c, prod_c, sum_c;
    logic                        sat3_c, sat4_c;
    logic                        unused_bits;

    assign en        = !fp_valid_q || io.fp_ready;
    assign accept    = io.adc_valid && en && !clear;
    assign win_first = (cnt_q == '0);
    assign win_last  = (AVG_LOG2 == 0) || (cnt_q == CW'((1 << AVG_LOG2) - 1));
    assign code_ext  = AW'($signed(io.adc_code));
    assign acc_sum   = win_first ? code_ext : acc_q + code_ext;
    assign avg_full  = acc_sum >>> AVG_LOG2;

    always_comb begin
        avg_fp  = FP_WIDTH'(s1_avg_q) << FRAC;
        s2_full = PW'(avg_fp) * PW'(K_SCALE);
        volts_c = s2_full[PW-1-INT_WIDTH -: FP_WIDTH];

        s3_full = PW'(s2_volts_q) * PW'($signed(ADC_CAL_GAIN));
        s3_hi   = s3_full[PW-1 -: INT_WIDTH+1];
        sat3_c  = !((&s3_hi) || !(|s3_hi));
        prod_c  = sat3_c ? (s3_full[PW-1] ? SAT_MIN : SAT_MAX)
                         : s3_full[PW-1-INT_WIDTH -: FP_WIDTH];

        sum    = {s3_prod_q[FP_WIDTH-1], s3_prod_q} + {ADC_CAL_OFFSET[FP_WIDTH-1], ADC_CAL_OFFSET};
        sat4_c = sum[FP_WIDTH] ^ sum[FP_WIDTH-1];
        sum_c  = sat4_c ? (sum[FP_WIDTH] ? SAT_MIN : SAT_MAX) : sum[FP_WIDTH-1:0];
    end

    assign unused_bits = ^{s2_full[FRAC-1:0], s2_full[PW-1 -: INT_WIDTH], s3_full[FRAC-1:0], avg_full};

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        s1_valid_d = s1_valid_q;
        s1_avg_d   = s1_avg_q;
        s2_valid_d = s2_valid_q;
        s2_volts_d = s2_volts_q;
        s3_valid_d = s3_valid_q;
        s3_sat_d   = s3_sat_q;
        s3_prod_d  = s3_prod_q;
        fp_valid_d = fp_valid_q;
        sat_flag_d = sat_flag_q;
        fp_out_d   = fp_out_q;

        // clear flushes every valid even while stalled; datapath regs simply keep stale data
        if (clear) begin
            acc_d      = '0;
            cnt_d      = '0;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
            fp_valid_d = 1'b0;
        end else if (en) begin
            s1_valid_d = 1'b0;
            if (accept) begin
                acc_d = acc_sum;
                if (win_last) begin
                    cnt_d      = '0;
                    s1_valid_d = 1'b1;
                    s1_avg_d   = avg_full[ADC_WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            s2_valid_d = s1_valid_q;
            s2_volts_d = volts_c;
            s3_valid_d = s2_valid_q;
            s3_prod_d  = prod_c;
            s3_sat_d   = sat3_c;
            fp_valid_d = s3_valid_q;
            if (s3_valid_q) begin
                fp_out_d   = sum_c;
                sat_flag_d = s3_sat_q || sat4_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_avg_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_volts_q <= '0;
            s3_valid_q <= 1'b0;
            s3_sat_q   <= 1'b0;
            s3_prod_q  <= '0;
            fp_valid_q <= 1'b0;
            sat_flag_q <= 1'b0;
            fp_out_q   <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_avg_q   <= s1_avg_d;
            s2_valid_q <= s2_valid_d;
            s2_volts_q <= s2_volts_d;
            s3_valid_q <= s3_valid_d;
            s3_sat_q   <= s3_sat_d;
            s3_prod_q  <= s3_prod_d;
            fp_valid_q <= fp_valid_d;
            sat_flag_q <= sat_flag_d;
            fp_out_q   <= fp_out_d;
        end
    end

    assign io.adc_ready = en;
    assign io.fp_out    = fp_out_q;
    assign io.fp_valid  = fp_valid_q;
    assign io.sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_adc_fp.sv
// Directed bench for adc_fp: one instance without averaging, one with a 4-sample window.
module tb_adc_fp;
    localparam logic [63:0] ONE  = 64'h0001_0000_0000_0000;
    localparam logic [63:0] HALF = 64'h0000_8000_0000_0000;

    typedef struct {
        int          code;
        logic [63:0] gain;
        logic [63:0] offset;
        logic [63:0] exp_out;
        logic        exp_sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear0, clear2;
    logic [63:0] gain0, off0, gain2, off2;
    int          tests = 0;
    int          fails = 0;
    int          n2 = 0;
    logic [63:0] last2;
    vec_t        vecs[11];

    adc_fp_if #(.FP_WIDTH(64), .ADC_WIDTH(14)) if0 ();
    adc_fp_if #(.FP_WIDTH(64), .ADC_WIDTH(14)) if2 ();

    adc_fp #(.FP_WIDTH(64), .INT_WIDTH(16), .ADC_WIDTH(14), .AVG_LOG2(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear0),
        .ADC_CAL_GAIN(gain0), .ADC_CAL_OFFSET(off0), .io(if0)
    );

    adc_fp #(.FP_WIDTH(64), .INT_WIDTH(16), .ADC_WIDTH(14), .AVG_LOG2(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2),
        .ADC_CAL_GAIN(gain2), .ADC_CAL_OFFSET(off2), .io(if2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if2.fp_valid && if2.fp_ready) begin
            n2++;
            last2 = if2.fp_out;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic put2(input int c, input logic v, input logic clr);
        @(negedge clk);
        if2.adc_code  = 14'(c);
        if2.adc_valid = v;
        clear2        = clr;
    endtask

    function automatic logic [63:0] volts_of(input int code);
        return 64'(longint'(code) * -(64'sd343597383680));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, nb, idx, rx, cyc, seen;
        logic [63:0] got, held;
        logic        gsat, held_v;

        vecs[0]  = '{4096,  ONE,                    64'h0,                  64'hFFFB_0000_0000_0000, 1'b0};
        vecs[1]  = '{-8192, ONE,                    64'h0,                  64'h000A_0000_0000_0000, 1'b0};
        vecs[2]  = '{8191,  ONE,                    64'h0,                  64'hFFF6_0050_0000_0000, 1'b0};
        vecs[3]  = '{0,     ONE,                    ONE,                    ONE,                     1'b0};
        vecs[4]  = '{-8192, 64'h7FFF_0000_0000_0000, 64'h0,                  64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[5]  = '{-8192, ONE,                    64'h7FFF_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[6]  = '{8191,  64'h7FFF_0000_0000_0000, 64'h0,                  64'h8000_0000_0000_0000, 1'b1};
        vecs[7]  = '{4096,  ONE,                    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1};
        vecs[8]  = '{4096,  64'hFFFF_0000_0000_0000, 64'h0,                  64'h0005_0000_0000_0000, 1'b0};
        vecs[9]  = '{-8192, HALF,                   64'h0,                  64'h0005_0000_0000_0000, 1'b0};
        vecs[10] = '{0,     ONE,                    64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};

        rst_n = 1'b0;
        clear0 = 1'b0; clear2 = 1'b0;
        gain0 = ONE; off0 = '0; gain2 = ONE; off2 = HALF;
        if0.adc_code = '0; if0.adc_valid = 1'b0; if0.fp_ready = 1'b1;
        if2.adc_code = '0; if2.adc_valid = 1'b0; if2.fp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_fp_valid0", 64'(if0.fp_valid), 64'd0);
        check("reset_fp_out0", if0.fp_out, 64'd0);
        check("reset_sat0", 64'(if0.sat_flag), 64'd0);
        check("reset_adc_ready0", 64'(if0.adc_ready), 64'd1);
        check("reset_fp_valid2", 64'(if2.fp_valid), 64'd0);
        check("reset_adc_ready2", 64'(if2.adc_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            gain0 = vecs[i].gain;
            off0  = vecs[i].offset;
            if0.adc_code  = 14'(vecs[i].code);
            if0.adc_valid = 1'b1;
            lat = 0; got = '0; gsat = 1'b0;
            for (int t = 1; t <= 12; t++) begin
                @(negedge clk);
                if (t == 1) if0.adc_valid = 1'b0;
                if (if0.fp_valid && lat == 0) begin
                    lat = t; got = if0.fp_out; gsat = if0.sat_flag;
                end
            end
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d_fp_out", i), got, vecs[i].exp_out);
            check($sformatf("vec%0d_sat", i), 64'(gsat), 64'(vecs[i].exp_sat));
        end

        // 4-sample window with a gap; avg 250 plus 0.5 offset
        nb = n2;
        put2(100, 1, 0); put2(200, 1, 0); put2(0, 0, 0); put2(300, 1, 0); put2(400, 1, 0);
        put2(0, 0, 0);
        repeat (2) @(negedge clk);
        check("avg_latency_cycle3", 64'(if2.fp_valid), 64'd0);
        @(negedge clk);
        check("avg_latency_cycle4", 64'(if2.fp_valid), 64'd1);
        check("avg_250_out", if2.fp_out, 64'h0000_31E0_0000_0000);
        repeat (6) @(negedge clk);
        check("avg_250_count", 64'(n2 - nb), 64'd1);

        // floor toward -inf: -9/4 -> -3
        off2 = '0;
        nb = n2;
        put2(-3, 1, 0); put2(-2, 1, 0); put2(-2, 1, 0); put2(-2, 1, 0); put2(0, 0, 0);
        repeat (6) @(negedge clk);
        check("avg_floor_count", 64'(n2 - nb), 64'd1);
        check("avg_floor_out", last2, 64'h0000_00F0_0000_0000);

        // clear together with third sample discards the partial window
        nb = n2;
        put2(1000, 1, 0); put2(1000, 1, 0); put2(2000, 1, 1);
        put2(4, 1, 0); put2(8, 1, 0); put2(12, 1, 0); put2(16, 1, 0); put2(0, 0, 0);
        repeat (6) @(negedge clk);
        check("clear_count", 64'(n2 - nb), 64'd1);
        check("clear_out", last2, 64'hFFFF_FCE0_0000_0000);

        // backpressure: fp_ready low for cycles 5..12
        gain0 = ONE; off0 = '0;
        idx = 0; rx = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (rx < 10 && cyc < 100) begin
            @(negedge clk);
            if0.fp_ready = !(cyc >= 5 && cyc <= 12);
            if (idx < 10) begin
                if0.adc_code  = 14'(1000 * idx - 4500);
                if0.adc_valid = 1'b1;
            end else begin
                if0.adc_valid = 1'b0;
            end
            #1;
            check($sformatf("bp_adc_ready_c%0d", cyc), 64'(if0.adc_ready),
                  64'(!(if0.fp_valid && !if0.fp_ready)));
            if (if0.fp_valid && !if0.fp_ready) begin
                if (held_v) check($sformatf("bp_hold_c%0d", cyc), if0.fp_out, held);
                held_v = 1'b1;
                held   = if0.fp_out;
            end else begin
                held_v = 1'b0;
            end
            if (if0.fp_valid && if0.fp_ready) begin
                check($sformatf("bp_out%0d", rx), if0.fp_out, volts_of(1000 * rx - 4500));
                rx++;
            end
            if (if0.adc_valid && if0.adc_ready) idx++;
            cyc++;
        end
        check("bp_received", 64'(rx), 64'd10);
        if0.adc_valid = 1'b0;
        if0.fp_ready  = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (if0.fp_valid) seen++;
        end
        check("bp_no_duplicate", 64'(seen), 64'd0);

        // asynchronous reset with a stalled, full pipeline and a half window
        if0.fp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if0.adc_code = 14'(100 * (k + 1)); if0.adc_valid = 1'b1;
            if (k < 2) begin
                if2.adc_code = 14'(1000); if2.adc_valid = 1'b1;
            end else begin
                if2.adc_valid = 1'b0;
            end
        end
        @(negedge clk);
        if0.adc_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_valid0", 64'(if0.fp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid0", 64'(if0.fp_valid), 64'd0);
        check("async_reset_out0", if0.fp_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        if0.fp_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (if0.fp_valid) seen++;
        end
        check("post_reset_no_stale0", 64'(seen), 64'd0);
        nb = n2;
        put2(4, 1, 0); put2(8, 1, 0); put2(12, 1, 0); put2(0, 0, 0);
        repeat (6) @(negedge clk);
        check("post_reset_no_early2", 64'(n2 - nb), 64'd0);
        put2(16, 1, 0); put2(0, 0, 0);
        repeat (6) @(negedge clk);
        check("post_reset_count2", 64'(n2 - nb), 64'd1);
        check("post_reset_out2", last2, 64'hFFFF_FCE0_0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
